// File: rtl/video_bus_pkg.sv
// Shared encodings and slot geometry for the time-division SRAM bus.
package video_bus_pkg;

  typedef enum logic [1:0] {
    ADDR_SEL_VIDEO  = 2'd0,
    ADDR_SEL_BRIDGE = 2'd1,
    ADDR_SEL_CPU    = 2'd2,
    ADDR_SEL_IDLE   = 2'd3
  } addr_sel_e;

  localparam int SLOTS_PER_FRAME = 16;
  localparam int WINDOW_LEN      = 3;

  localparam int DEFAULT_VRAM_SLOT   = 0;
  localparam int DEFAULT_VROM_SLOT   = 4;
  localparam int DEFAULT_BRIDGE_SLOT = 8;
  localparam int DEFAULT_CPU_SLOT    = 12;

  function automatic logic windows_disjoint(input int a, input int b);
    return (a + WINDOW_LEN <= b) || (b + WINDOW_LEN <= a);
  endfunction

  function automatic logic window_fits(input int start);
    return (start >= 0) && (start + WINDOW_LEN <= SLOTS_PER_FRAME);
  endfunction

endpackage

// File: rtl/bus_window.sv
// Decodes one three-slot bus window from a slot counter value.
module bus_window
  import video_bus_pkg::*;
(
  input  logic [3:0] count,
  input  logic [3:0] start,
  input  logic       enable,
  input  logic       write,
  output logic       active,
  output logic       oe,
  output logic       we,
  output logic       last
);

  logic [3:0] offset;
  logic       in_window;

  assign offset    = count - start;
  assign in_window = enable && (count >= start) && (offset < 4'(WINDOW_LEN));

  // Write strobe sits in the middle slot so address is stable one slot either side.
  assign active = in_window;
  assign oe     = in_window && !write;
  assign we     = in_window && write && (offset == 4'd1);
  assign last   = in_window && (offset == 4'(WINDOW_LEN - 1));

endmodule

// File: rtl/sram_bus_sequencer.sv
// Shares one 8-bit SRAM/char-ROM bus between video, CPU and bridge in a
// 16-slot frame; every output is registered from the next slot value.
module sram_bus_sequencer
  import video_bus_pkg::*;
#(
  parameter int VRAM_SLOT   = DEFAULT_VRAM_SLOT,
  parameter int VROM_SLOT   = DEFAULT_VROM_SLOT,
  parameter int BRIDGE_SLOT = DEFAULT_BRIDGE_SLOT,
  parameter int CPU_SLOT    = DEFAULT_CPU_SLOT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_we,
  input  logic       bridge_req,
  input  logic       bridge_we,
  input  logic [7:0] sram_data_in,
  output logic [1:0] addr_sel,
  output logic       sram_oe_n,
  output logic       sram_we_n,
  output logic       video_ram_strobe,
  output logic       video_rom_strobe,
  output logic       cpu_clk,
  output logic       bridge_ack,
  output logic [7:0] bridge_rd_data,
  output logic [7:0] cpu_rd_data,
  output logic [3:0] slot
);

  localparam logic [3:0] VRAM_START   = 4'(VRAM_SLOT);
  localparam logic [3:0] VROM_START   = 4'(VROM_SLOT);
  localparam logic [3:0] BRIDGE_START = 4'(BRIDGE_SLOT);
  localparam logic [3:0] CPU_START    = 4'(CPU_SLOT);

  if (!windows_disjoint(VRAM_SLOT, VROM_SLOT) || !windows_disjoint(VRAM_SLOT, BRIDGE_SLOT) ||
      !windows_disjoint(VRAM_SLOT, CPU_SLOT)  || !windows_disjoint(VROM_SLOT, BRIDGE_SLOT) ||
      !windows_disjoint(VROM_SLOT, CPU_SLOT)  || !windows_disjoint(BRIDGE_SLOT, CPU_SLOT)) begin : g_overlap
    $error("sram_bus_sequencer: bus windows overlap");
  end
  if (!window_fits(VRAM_SLOT) || !window_fits(VROM_SLOT) ||
      !window_fits(BRIDGE_SLOT) || !window_fits(CPU_SLOT)) begin : g_wrap
    $error("sram_bus_sequencer: a bus window wraps past the end of the frame");
  end
  if (CPU_SLOT < 8 || CPU_SLOT > 12) begin : g_cpu_phase
    $error("sram_bus_sequencer: CPU window must sit in the high half of phi2");
  end

  logic [3:0] count_q;
  logic [3:0] count_next;
  logic       grant_q, grant_next;
  logic       bridge_wr_q, bridge_wr_next;
  logic       cpu_wr_q, cpu_wr_next;
  logic       bridge_last_q, cpu_last_q;
  addr_sel_e  addr_sel_q, addr_sel_next;
  logic       oe_next, we_next;

  logic vram_active, vram_oe, vram_we, vram_last;
  logic vrom_active, vrom_oe, vrom_we, vrom_last;
  logic bridge_active, bridge_oe, bridge_we_win, bridge_last;
  logic cpu_active, cpu_oe, cpu_we_win, cpu_last;
  logic unused_video_bits;

  assign count_next = count_q + 4'd1;

  // Grant and direction are latched on window entry and held for the whole window.
  assign grant_next     = (count_next == BRIDGE_START) ? bridge_req : grant_q;
  assign bridge_wr_next = (count_next == BRIDGE_START) ? bridge_we  : bridge_wr_q;
  assign cpu_wr_next    = (count_next == CPU_START)    ? cpu_we     : cpu_wr_q;

  bus_window u_vram (
    .count(count_next), .start(VRAM_START), .enable(1'b1), .write(1'b0),
    .active(vram_active), .oe(vram_oe), .we(vram_we), .last(vram_last)
  );

  bus_window u_vrom (
    .count(count_next), .start(VROM_START), .enable(1'b1), .write(1'b0),
    .active(vrom_active), .oe(vrom_oe), .we(vrom_we), .last(vrom_last)
  );

  bus_window u_bridge (
    .count(count_next), .start(BRIDGE_START), .enable(grant_next), .write(bridge_wr_next),
    .active(bridge_active), .oe(bridge_oe), .we(bridge_we_win), .last(bridge_last)
  );

  bus_window u_cpu (
    .count(count_next), .start(CPU_START), .enable(1'b1), .write(cpu_wr_next),
    .active(cpu_active), .oe(cpu_oe), .we(cpu_we_win), .last(cpu_last)
  );

  assign unused_video_bits = ^{vram_we, vram_last, vrom_we, vrom_last};

  always_comb begin
    addr_sel_next = ADDR_SEL_IDLE;
    if (vram_active || vrom_active) begin
      addr_sel_next = ADDR_SEL_VIDEO;
    end else if (bridge_active) begin
      addr_sel_next = ADDR_SEL_BRIDGE;
    end else if (cpu_active) begin
      addr_sel_next = ADDR_SEL_CPU;
    end
    oe_next = vram_oe || vrom_oe || bridge_oe || cpu_oe;
    we_next = bridge_we_win || cpu_we_win;
  end

  // Reset aborts any window in flight: strobes drop and no ack or capture follows.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q          <= 4'd0;
      grant_q          <= 1'b0;
      bridge_wr_q      <= 1'b0;
      cpu_wr_q         <= 1'b0;
      bridge_last_q    <= 1'b0;
      cpu_last_q       <= 1'b0;
      addr_sel_q       <= ADDR_SEL_IDLE;
      sram_oe_n        <= 1'b1;
      sram_we_n        <= 1'b1;
      video_ram_strobe <= 1'b0;
      video_rom_strobe <= 1'b0;
      cpu_clk          <= 1'b0;
      bridge_ack       <= 1'b0;
      bridge_rd_data   <= 8'h00;
      cpu_rd_data      <= 8'h00;
    end else begin
      count_q          <= count_next;
      grant_q          <= grant_next;
      bridge_wr_q      <= bridge_wr_next;
      cpu_wr_q         <= cpu_wr_next;
      bridge_last_q    <= bridge_last;
      cpu_last_q       <= cpu_last;
      addr_sel_q       <= addr_sel_next;
      sram_oe_n        <= !oe_next;
      sram_we_n        <= !we_next;
      video_ram_strobe <= vram_active;
      video_rom_strobe <= vrom_active;
      cpu_clk          <= count_next[3];
      bridge_ack       <= bridge_last_q;
      if (bridge_last_q && !bridge_wr_q) begin
        bridge_rd_data <= sram_data_in;
      end
      if (cpu_last_q && !cpu_wr_q) begin
        cpu_rd_data <= sram_data_in;
      end
    end
  end

  assign addr_sel = addr_sel_q;
  assign slot     = count_q;

  a_no_oe_we_overlap: assert property (@(posedge clk) disable iff (reset)
    !(!sram_oe_n && !sram_we_n));

  a_single_owner: assert property (@(posedge clk) disable iff (reset)
    $onehot0({vram_active || vrom_active, bridge_active, cpu_active}));

  a_we_mid_window: assert property (@(posedge clk) disable iff (reset)
    !sram_we_n |-> (slot == BRIDGE_START + 4'd1 || slot == CPU_START + 4'd1));

endmodule

// File: tb/tb_sram_bus_sequencer.sv
// Self-checking bench: slot-table reference model of the bus frame compared every clock.
module tb_sram_bus_sequencer;

  localparam int V = 0;
  localparam int R = 4;
  localparam int B = 8;
  localparam int C = 12;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cpu_we = 1'b0;
  logic       bridge_req = 1'b0;
  logic       bridge_we = 1'b0;
  logic [7:0] sram_data_in = 8'h00;
  logic [1:0] addr_sel;
  logic       sram_oe_n, sram_we_n, video_ram_strobe, video_rom_strobe, cpu_clk, bridge_ack;
  logic [7:0] bridge_rd_data, cpu_rd_data;
  logic [3:0] slot;

  sram_bus_sequencer #(
    .VRAM_SLOT(V), .VROM_SLOT(R), .BRIDGE_SLOT(B), .CPU_SLOT(C)
  ) dut (
    .clk(clk), .reset(reset), .cpu_we(cpu_we), .bridge_req(bridge_req),
    .bridge_we(bridge_we), .sram_data_in(sram_data_in), .addr_sel(addr_sel),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .video_ram_strobe(video_ram_strobe),
    .video_rom_strobe(video_rom_strobe), .cpu_clk(cpu_clk), .bridge_ack(bridge_ack),
    .bridge_rd_data(bridge_rd_data), .cpu_rd_data(cpu_rd_data), .slot(slot)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] slot;
    logic [1:0] addr_sel;
    logic       oe_n, we_n, vram, vrom, cpu_clk, ack;
    logic [7:0] brd, crd;
  } obs_t;

  localparam obs_t RESET_VEC = '{slot: 4'd0, addr_sel: 2'd3, oe_n: 1'b1, we_n: 1'b1,
                                 vram: 1'b0, vrom: 1'b0, cpu_clk: 1'b0, ack: 1'b0,
                                 brd: 8'h00, crd: 8'h00};

  obs_t got;
  assign got = {slot, addr_sel, sram_oe_n, sram_we_n, video_ram_strobe, video_rom_strobe,
                cpu_clk, bridge_ack, bridge_rd_data, cpu_rd_data};

  int         n_vec = 0;
  int         n_miss = 0;
  int         exp_slot;
  logic       g, bw, cw, fresh;
  logic [7:0] exp_brd, exp_crd;

  task automatic model_reset();
    exp_slot = 0; g = 1'b0; bw = 1'b0; cw = 1'b0; fresh = 1'b1;
    exp_brd = 8'h00; exp_crd = 8'h00;
  endtask

  // Frame table: who owns the bus in each slot given this frame's grant and directions.
  function automatic obs_t model();
    obs_t e;
    logic vram_on, vrom_on, br_on, cpu_on;
    vram_on = (exp_slot >= V) && (exp_slot < V + 3) && !fresh;
    vrom_on = (exp_slot >= R) && (exp_slot < R + 3);
    br_on   = g && (exp_slot >= B) && (exp_slot < B + 3);
    cpu_on  = (exp_slot >= C) && (exp_slot < C + 3);
    e.slot     = 4'(exp_slot);
    e.addr_sel = (vram_on || vrom_on) ? 2'd0 : br_on ? 2'd1 : cpu_on ? 2'd2 : 2'd3;
    e.oe_n     = !(vram_on || vrom_on || (br_on && !bw) || (cpu_on && !cw));
    e.we_n     = !((br_on && bw && exp_slot == B + 1) || (cpu_on && cw && exp_slot == C + 1));
    e.vram     = vram_on;
    e.vrom     = vrom_on;
    e.cpu_clk  = (exp_slot >= 8);
    e.ack      = g && (exp_slot == B + 3);
    e.brd      = exp_brd;
    e.crd      = exp_crd;
    return e;
  endfunction

  task automatic advance(input logic req, input logic we, input logic cwe, input logic [7:0] data);
    bridge_req = req; bridge_we = we; cpu_we = cwe; sram_data_in = data;
    if (exp_slot == B - 1) begin g = req; bw = we; end
    if (exp_slot == C - 1) cw = cwe;
    if (exp_slot == B + 2 && g && !bw) exp_brd = data;
    if (exp_slot == C + 2 && !cw) exp_crd = data;
    @(posedge clk);
    exp_slot = (exp_slot + 1) % 16;
    fresh = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    n_vec++;
    if (got !== RESET_VEC) begin
      n_miss++; $display("FAIL reset_hold got=%h expected=%h", got, RESET_VEC);
    end
    @(negedge clk);
    n_vec++;
    if (got !== RESET_VEC) begin
      n_miss++; $display("FAIL reset_held_edge got=%h expected=%h", got, RESET_VEC);
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_frames();
    obs_t e;
    int   hi = 0, nram = 0, nrom = 0;
    for (int i = 0; i < 48; i++) begin
      e = model();
      n_vec++;
      if (got !== e) begin
        n_miss++; $display("FAIL frames slot=%0d got=%h expected=%h", exp_slot, got, e);
      end
      hi += int'(cpu_clk); nram += int'(video_ram_strobe); nrom += int'(video_rom_strobe);
      advance(1'b0, 1'b0, 1'b0, 8'($urandom));
    end
    n_vec++;
    if (hi !== 24 || nram !== 8 || nrom !== 9) begin
      n_miss++; $display("FAIL frame_counts got=%0d/%0d/%0d expected=24/8/9", hi, nram, nrom);
    end
  endtask

  task automatic test_bridge_read();
    obs_t e;
    int   acks = 0, ack_slot = -1;
    logic done = 1'b0;
    while (exp_slot != B - 1) advance(1'b0, 1'b0, 1'b0, 8'($urandom));
    for (int i = 0; i < 20; i++) begin
      e = model();
      n_vec++;
      if (got !== e) begin
        n_miss++; $display("FAIL bridge_read slot=%0d got=%h expected=%h", exp_slot, got, e);
      end
      if (bridge_ack) begin acks++; ack_slot = exp_slot; done = 1'b1; end
      advance(!done, 1'b0, 1'b0, (exp_slot == B + 2) ? 8'hA5 : 8'($urandom));
    end
    n_vec++;
    if (acks !== 1 || ack_slot !== B + 3 || bridge_rd_data !== 8'hA5) begin
      n_miss++;
      $display("FAIL bridge_read_result got acks=%0d slot=%0d data=%h expected 1/%0d/a5",
               acks, ack_slot, bridge_rd_data, B + 3);
    end
  endtask

  task automatic test_bridge_write();
    obs_t e;
    int   acks = 0, we_low = 0, we_slot = -1;
    logic done = 1'b0;
    while (exp_slot != B - 1) advance(1'b0, 1'b0, 1'b0, 8'($urandom));
    for (int i = 0; i < 32; i++) begin
      e = model();
      n_vec++;
      if (got !== e) begin
        n_miss++; $display("FAIL bridge_write slot=%0d got=%h expected=%h", exp_slot, got, e);
      end
      if (bridge_ack) begin acks++; done = 1'b1; end
      if (!sram_we_n) begin we_low++; we_slot = exp_slot; end
      advance(!done, 1'b1, 1'b0, 8'($urandom));
    end
    n_vec++;
    if (acks !== 1 || we_low !== 1 || we_slot !== B + 1) begin
      n_miss++;
      $display("FAIL bridge_write_result got acks=%0d we_low=%0d we_slot=%0d expected 1/1/%0d",
               acks, we_low, we_slot, B + 1);
    end
  endtask

  task automatic test_late_request();
    obs_t e;
    int   cnt, lat = -1;
    logic done = 1'b0;
    while (exp_slot != B + 1) advance(1'b0, 1'b0, 1'b0, 8'($urandom));
    advance(1'b1, 1'b0, 1'b0, 8'($urandom));
    cnt = 1;
    for (int i = 0; i < 30; i++) begin
      e = model();
      n_vec++;
      if (got !== e) begin
        n_miss++; $display("FAIL late_request slot=%0d got=%h expected=%h", exp_slot, got, e);
      end
      if (bridge_ack && lat < 0) begin lat = cnt; done = 1'b1; end
      advance(!done, 1'b0, 1'b0, 8'($urandom));
      cnt++;
    end
    n_vec++;
    if (lat !== 18) begin
      n_miss++; $display("FAIL late_request_latency got=%0d expected=18", lat);
    end
  endtask

  task automatic test_cpu();
    obs_t e;
    int   we_low = 0, we_slot = -1;
    while (exp_slot != C - 1) advance(1'b0, 1'b0, 1'b0, 8'($urandom));
    for (int i = 0; i < 21; i++) begin
      e = model();
      n_vec++;
      if (got !== e) begin
        n_miss++; $display("FAIL cpu slot=%0d got=%h expected=%h", exp_slot, got, e);
      end
      if (!sram_we_n) begin we_low++; we_slot = exp_slot; end
      advance(1'b0, 1'b0, (i >= 16), (exp_slot == C + 2) ? 8'h3C : 8'($urandom));
    end
    n_vec++;
    if (cpu_rd_data !== 8'h3C || we_low !== 1 || we_slot !== C + 1) begin
      n_miss++;
      $display("FAIL cpu_result got data=%h we_low=%0d we_slot=%0d expected 3c/1/%0d",
               cpu_rd_data, we_low, we_slot, C + 1);
    end
  endtask

  task automatic test_random();
    obs_t e;
    for (int i = 0; i < 16 * 1000; i++) begin
      e = model();
      n_vec++;
      if (got !== e) begin
        n_miss++; $display("FAIL random slot=%0d got=%h expected=%h", exp_slot, got, e);
      end
      n_vec++;
      if (!sram_oe_n && !sram_we_n) begin
        n_miss++; $display("FAIL oe_we_overlap slot=%0d got oe_n=0 we_n=0 expected not both low", exp_slot);
      end
      advance(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
    end
  endtask

  task automatic test_reset_mid_write();
    obs_t e;
    int   acks = 0;
    while (exp_slot != B - 1) advance(1'b0, 1'b0, 1'b0, 8'($urandom));
    advance(1'b1, 1'b1, 1'b0, 8'($urandom));
    advance(1'b1, 1'b1, 1'b0, 8'($urandom));
    e = model();
    n_vec++;
    if (got !== e) begin
      n_miss++; $display("FAIL reset_mid_pre slot=%0d got=%h expected=%h", exp_slot, got, e);
    end
    reset = 1'b1;
    #1;
    n_vec++;
    if (got !== RESET_VEC) begin
      n_miss++; $display("FAIL reset_mid_async got=%h expected=%h", got, RESET_VEC);
    end
    bridge_req = 1'b0; bridge_we = 1'b0;
    @(negedge clk);
    n_vec++;
    if (got !== RESET_VEC) begin
      n_miss++; $display("FAIL reset_mid_held got=%h expected=%h", got, RESET_VEC);
    end
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 20; i++) begin
      e = model();
      n_vec++;
      if (got !== e) begin
        n_miss++; $display("FAIL reset_mid_restart slot=%0d got=%h expected=%h", exp_slot, got, e);
      end
      acks += int'(bridge_ack);
      advance(1'b0, 1'b0, 1'b0, 8'($urandom));
    end
    n_vec++;
    if (acks !== 0) begin
      n_miss++; $display("FAIL reset_mid_ack got=%0d expected=0", acks);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_frames();
    test_bridge_read();
    test_bridge_write();
    test_late_request();
    test_cpu();
    test_random();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/sram_bus_sequencer.md
Name: sram_bus_sequencer

Overview:
Time-division sequencer sharing the single 8-bit SRAM/char-ROM bus between video fetch, the 6502 CPU and the host bridge (SPI). Divides the 16 MHz system clock into a repeating 16-slot, 1 µs bus frame and generates:
- the video RAM/ROM fetch strobes consumed by the video generator;
- the CPU phase clock;
- SRAM control and address-mux select;
- a req/ack handshake for the bridge.

Parameters:
VRAM_SLOT, 0, first slot of video RAM fetch window (3 slots)
VROM_SLOT, 4, first slot of character ROM fetch window (3 slots)
BRIDGE_SLOT, 8, first slot of bridge access window (3 slots)
CPU_SLOT, 12, first slot of CPU access window (3 slots)

Ports:
clk  in  1  16 MHz system clock
reset  in  1  asynchronous, active-high
cpu_we  in  1  CPU write request (R/W low), sampled at CPU_SLOT
bridge_req  in  1  bridge access request, level, held until bridge_ack
bridge_we  in  1  bridge write (1) / read (0), qualified by bridge_req
sram_data_in  in  8  SRAM/ROM read data
addr_sel  out  2  address/data mux: 0 video, 1 bridge, 2 CPU, 3 idle
sram_oe_n  out  1  SRAM output enable, active low
sram_we_n  out  1  SRAM write enable, active low
video_ram_strobe  out  1  video RAM fetch strobe; video latches data on falling edge
video_rom_strobe  out  1  char ROM fetch strobe; video latches data on falling edge
cpu_clk  out  1  CPU phi2, 1 MHz, 50% duty
bridge_ack  out  1  one-clk pulse, bridge access complete
bridge_rd_data  out  8  data captured on bridge read
cpu_rd_data  out  8  data captured on CPU read
slot  out  4  current slot number (debug/trace)

Behaviour:
- 4-bit slot counter increments every clk and wraps 15->0.
- All outputs are registered. Each is decoded from the next counter value, so an output is valid for exactly the clocks of its slot(s) and is glitch-free.
- Reset: counter 0; addr_sel 3; sram_oe_n 1; sram_we_n 1; both strobes 0; cpu_clk 0; bridge_ack 0; bridge_rd_data 0; cpu_rd_data 0.
  - Reset mid-window aborts the access immediately: no ack, no write completed, strobes drop.
  - Note that dropping a strobe produces a falling edge, which the video block treats as a fetch.
- Video RAM window, slots V..V+2: addr_sel 0, oe_n 0, video_ram_strobe 1.
- Video ROM window, slots R..R+2: addr_sel 0, oe_n 0, video_rom_strobe 1.
- Video windows run every frame unconditionally.
- Bridge window, slots B..B+2:
  - Arbitration: grant is decided once, on the clock entering slot B, from bridge_req. The granted flag is held for the window, so a late request waits for the next frame.
  - Granted read: addr_sel 1, oe_n 0 for B..B+2; bridge_rd_data <= sram_data_in on the edge leaving B+2.
  - Granted write: addr_sel 1, oe_n 1, we_n 0 in slot B+1 only, giving 1 slot of address setup/hold.
  - bridge_ack pulses high for the 1 clk following B+2 (slot B+3).
  - Requester may drop req in the ack cycle. A req still high at the next slot B is a new access (back-to-back rate: 1 per µs).
  - Not granted: addr_sel 3, oe_n 1, we_n 1, no ack.
- CPU window, slots C..C+2:
  - Always serviced: addr_sel 2.
  - Read (cpu_we 0 at C): oe_n 0; cpu_rd_data <= sram_data_in on the edge leaving C+2.
  - Write: oe_n 1, we_n 0 in slot C+1 only.
  - cpu_we is sampled once on entry to C.
- cpu_clk: 0 for slots 0..7, 1 for slots 8..15. The CPU window lies in the second half of phi2, so address has been stable for at least 4 slots.
- Remaining slots (3, 7, 11, 15) are idle: addr_sel 3, oe_n 1, we_n 1. These are bus-turnaround gaps.
- Invariants checked by assertion:
  - at most one of {video strobe, bridge grant, CPU window} is active per slot;
  - never oe_n=0 and we_n=0 together;
  - we_n low never in the first or last slot of a window.
- Parameter legality: windows must not overlap, must not wrap past 15, and CPU_SLOT must lie in 8..12. Checked by elaboration-time assertion.

Decomposition:
- Shared package video_bus_pkg holds:
  - ADDR_SEL_VIDEO / ADDR_SEL_BRIDGE / ADDR_SEL_CPU / ADDR_SEL_IDLE encodings;
  - SLOTS_PER_FRAME = 16 and WINDOW_LEN = 3;
  - default slot positions.
- One sub-module is natural: bus_window, instantiated 4 times.
  - Inputs: counter, start slot, enable, write.
  - Outputs: active, oe, we and end-of-window pulse.
- Top level muxes the four bus_window instances and owns the counter, grant flag and data capture registers.

Test Plan:
- Reset held, then released -> all outputs at reset values; slot counts 0..15; cpu_clk period 16 clk, high slots 8..15; video_ram_strobe high slots 0..2 and video_rom_strobe high slots 4..6, every frame.
- bridge_req=1, bridge_we=0, SRAM model returns 0xA5 in slot 10 -> addr_sel=1 and oe_n=0 slots 8..10; bridge_rd_data=0xA5; bridge_ack single pulse in slot 11.
- bridge_req=1, bridge_we=1 -> we_n=0 only in slot 9, oe_n=1 throughout; ack in slot 11; no bridge activity in the next frame once req is dropped at ack.
- bridge_req raised in slot 9 -> no grant this frame; grant at next slot 8; ack 18 clks after raise.
- cpu_we=0 with data 0x3C, then cpu_we=1 next frame -> cpu_rd_data=0x3C after slot 14; write frame has we_n=0 only in slot 13; assertion that oe_n and we_n are never both low passes over 1000 random frames with random bridge_req/cpu_we.
- Assert reset in slot 9 of a bridge write -> we_n returns 1 asynchronously, no bridge_ack; after release, sequence restarts at slot 0.
